// File: rtl/tt_lookup_engine.sv
// Runtime-programmable truth-table evaluator with a burst-load FSM and a 1-deep registered lookup stage.
// Optional feature: define TT_CHANGE_CNT_EN to add the change_cnt output-change counter.
module tt_lookup_engine #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             cfg_valid,
  input  logic [OUT_W-1:0] cfg_data,
  output logic             load_busy,
  output logic             load_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_vec
`ifdef TT_CHANGE_CNT_EN
  ,
  output logic [15:0]      change_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << IN_W;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state, state_next;
  logic [IN_W-1:0]  addr;
  logic [OUT_W-1:0] tbl [DEPTH];
  logic             cfg_write;
  logic             last_write;
  logic             done_next;
  logic             accept;

  assign cfg_write  = (state == LOAD) && cfg_valid;
  assign last_write = cfg_write && (addr == '1);
  assign load_busy  = (state == LOAD);
  assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A restart in the same cycle as the final write suppresses the done pulse.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (state == IDLE) begin
      if (load_start) state_next = LOAD;
    end else begin
      if (load_start) begin
        state_next = LOAD;
      end else if (last_write) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= done_next;
      if (load_start)     addr <= '0;
      else if (cfg_write) addr <= addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (cfg_write) begin
      tbl[addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_vec   <= tbl[in_vec];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef TT_CHANGE_CNT_EN
  logic [OUT_W-1:0] prev_vec;
  logic             handshake;

  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vec   <= '0;
      change_cnt <= '0;
    end else begin
      if (handshake) prev_vec <= out_vec;
      if (load_start)
        change_cnt <= '0;
      else if (handshake && (out_vec != prev_vec) && (change_cnt != '1))
        change_cnt <= change_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tt_lookup_engine.sv
// Directed self-checking bench for tt_lookup_engine (IN_W=3, OUT_W=3).
module tb_tt_lookup_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start, cfg_valid;
  logic [2:0] cfg_data;
  logic       load_busy, load_done;
  logic       in_valid, in_ready;
  logic [2:0] in_vec;
  logic       out_valid, out_ready;
  logic [2:0] out_vec;
`ifdef TT_CHANGE_CNT_EN
  logic [15:0] change_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [2:0] vals [8] = '{3'd7, 3'd6, 3'd4, 3'd5, 3'd1, 3'd0, 3'd2, 3'd3};

  tt_lookup_engine #(.IN_W(3), .OUT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .load_busy(load_busy), .load_done(load_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec)
`ifdef TT_CHANGE_CNT_EN
    , .change_cnt(change_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [2:0] idx, input logic [2:0] exp, input string name);
    in_valid = 1'b1; in_vec = idx; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_vec !== exp) begin
      errors++;
      $display("FAIL %s idx=%0d got valid=%b vec=%0d exp valid=1 vec=%0d", name, idx, out_valid, out_vec, exp);
    end
    tick();
  endtask

  task automatic load_vals();
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1; cfg_data = vals[i]; tick();
    end
    cfg_valid = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if (load_busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got busy=%b ov=%b ir=%b done=%b exp 0 0 1 0", load_busy, out_valid, in_ready, load_done);
    end
    do_lookup(3'd5, 3'd0, "reset_lookup5");
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drain got ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_load();
    int busy_cycles = 0;
    int dones = 0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    dones += int'(load_done);
    for (int i = 0; i < 8; i++) begin
      busy_cycles += int'(load_busy);
      cfg_valid = 1'b1; cfg_data = vals[i];
      tick();
      dones += int'(load_done);
    end
    cfg_valid = 1'b0;
    checks++;
    if (load_done !== 1'b1 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL load_end got done=%b busy=%b exp 1 0", load_done, load_busy);
    end
    tick();
    dones += int'(load_done);
    checks++;
    if (busy_cycles != 8) begin
      errors++;
      $display("FAIL load_busy_cycles got %0d exp 8", busy_cycles);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL load_done_count got %0d exp 1", dones);
    end
    do_lookup(3'd3, 3'b101, "load_lookup3");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 3'd0;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== 3'b111) begin
      errors++;
      $display("FAIL bp_first got ir=%b ov=%b vec=%0d exp 0 1 7", in_ready, out_valid, out_vec);
    end
    in_vec = 3'd2;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 3'b111) begin
      errors++;
      $display("FAIL bp_hold got ov=%b vec=%0d exp 1 7", out_valid, out_vec);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 3'b100) begin
      errors++;
      $display("FAIL bp_second got ov=%b vec=%0d exp 1 4", out_valid, out_vec);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_restart();
    int ready_seen = 0;
    int dones = 0;
    // Leave a result pending across the load.
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 3'd3;
    tick();
    in_valid = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    in_valid = 1'b1; in_vec = 3'd2;
    for (int i = 0; i < 3; i++) begin
      ready_seen += int'(in_ready);
      cfg_valid = 1'b1; cfg_data = 3'd1; tick();
      dones += int'(load_done);
    end
    cfg_valid = 1'b0; load_start = 1'b1;
    ready_seen += int'(in_ready);
    tick();
    dones += int'(load_done);
    load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ready_seen += int'(in_ready);
      cfg_valid = 1'b1; cfg_data = 3'd6; tick();
      dones += int'(load_done);
    end
    cfg_valid = 1'b0; in_valid = 1'b0;
    tick();
    dones += int'(load_done);
    checks++;
    if (ready_seen != 0) begin
      errors++;
      $display("FAIL restart_in_ready got %0d ready cycles exp 0", ready_seen);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL restart_done_count got %0d exp 1", dones);
    end
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 3'b101) begin
      errors++;
      $display("FAIL restart_pending got ov=%b vec=%0d exp 1 5", out_valid, out_vec);
    end
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) do_lookup(3'(i), 3'd6, "restart_entry");
  endtask

  task automatic test_reset_mid_load();
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 3'd1;
    tick();
    in_valid = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_data = 3'd2; tick();
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (load_busy !== 1'b0 || out_valid !== 1'b0 || out_vec !== 3'd0) begin
      errors++;
      $display("FAIL midreset_async got busy=%b ov=%b vec=%0d exp 0 0 0", load_busy, out_valid, out_vec);
    end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle got ir=%b busy=%b exp 1 0", in_ready, load_busy);
    end
    for (int i = 0; i < 8; i++) do_lookup(3'(i), 3'd0, "midreset_entry");
  endtask

`ifdef TT_CHANGE_CNT_EN
  task automatic test_change_cnt();
    logic [2:0] seq [5] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    logic [2:0] exp [5] = '{3'd7, 3'd7, 3'd6, 3'd6, 3'd4};
    load_vals();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_vec = seq[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp[i]) begin
        errors++;
        $display("FAIL stream_%0d got ov=%b vec=%0d exp 1 %0d", i, out_valid, out_vec, exp[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (change_cnt !== 16'd3) begin
      errors++;
      $display("FAIL change_cnt got %0d exp 3", change_cnt);
    end
    load_start = 1'b1; tick(); load_start = 1'b0;
    checks++;
    if (change_cnt !== 16'd0) begin
      errors++;
      $display("FAIL change_cnt_clear got %0d exp 0", change_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_backpressure();
    test_restart();
    test_reset_mid_load();
`ifdef TT_CHANGE_CNT_EN
    test_change_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
